// File: rtl/player_renderer.sv
// player_renderer
// Redraws the player tile whenever its grid position or facing direction
// differs from what is currently on screen. A move erases the old tile to
// floor colour and then draws the new one; a rotation only redraws. Pixels
// are written one per clock into a VGA adapter write port.
//
// Ports:
//   clock, resetn          : clock, asynchronous active-low reset
//   x_position, y_position : requested player tile column/row (0..GRID-1)
//   dir                    : facing direction, 00=E 01=N 10=W 11=S
//   vga_x, vga_y           : pixel address for the adapter
//   vga_color              : RGB333 pixel colour
//   vga_write              : pixel write strobe
//   busy                   : high alongside every erase/draw pixel cycle
//   done                   : one-cycle pulse after a draw completes
module player_renderer #(
    parameter int         TILE         = 24,
    parameter int         GRID         = 20,
    parameter int         X_OFF        = 80,
    parameter int         Y_OFF        = 0,
    parameter int         NOSE         = 6,
    parameter logic [8:0] FLOOR_COLOR  = 9'h000,
    parameter logic [8:0] PLAYER_COLOR = 9'h1C0,
    parameter logic [8:0] NOSE_COLOR   = 9'h1FF
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [4:0] x_position,
    input  logic [4:0] y_position,
    input  logic [1:0] dir,
    output logic [9:0] vga_x,
    output logic [8:0] vga_y,
    output logic [8:0] vga_color,
    output logic       vga_write,
    output logic       busy,
    output logic       done
);
    localparam int CW   = $clog2(TILE);
    localparam int M_LO = TILE / 3;
    localparam int M_HI = (2 * TILE) / 3;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_PEND, S_ERASE, S_DRAW, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      drawn_x_q, drawn_x_d, drawn_y_q, drawn_y_d;
    logic [1:0]      drawn_dir_q, drawn_dir_d;
    logic [4:0]      tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [1:0]      tgt_dir_q, tgt_dir_d;
    logic [CW-1:0]   px_q, px_d, py_q, py_d;
    logic [9:0]      vga_x_q, vga_x_d;
    logic [8:0]      vga_y_q, vga_y_d;
    logic [8:0]      vga_color_q, vga_color_d;
    logic            vga_write_q, vga_write_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Pixel datapath for the current raster position
    logic [4:0]  tile_x, tile_y;
    logic [31:0] px_v, py_v;
    logic        in_range, last_px, last_py, border;
    logic        mid_x, mid_y, nose;
    logic [8:0]  draw_color;

    always_comb begin
        // Erase walks the tile that is on screen; draw walks the target.
        tile_x   = (state_q == S_ERASE) ? drawn_x_q : tgt_x_q;
        tile_y   = (state_q == S_ERASE) ? drawn_y_q : tgt_y_q;
        px_v     = 32'(px_q);
        py_v     = 32'(py_q);
        in_range = (32'(tile_x) < GRID) && (32'(tile_y) < GRID);
        last_px  = (px_v == TILE - 1);
        last_py  = (py_v == TILE - 1);
        border   = (px_v == 0) || last_px || (py_v == 0) || last_py;
        mid_x    = (px_v >= M_LO) && (px_v < M_HI);
        mid_y    = (py_v >= M_LO) && (py_v < M_HI);
        unique case (tgt_dir_q)
            2'b00:   nose = mid_y && (px_v >= TILE - 1 - NOSE) && (px_v < TILE - 1);
            2'b01:   nose = mid_x && (py_v >= 1) && (py_v < 1 + NOSE);
            2'b10:   nose = mid_y && (px_v >= 1) && (px_v < 1 + NOSE);
            default: nose = mid_x && (py_v >= TILE - 1 - NOSE) && (py_v < TILE - 1);
        endcase
        if (border) begin
            draw_color = FLOOR_COLOR;
        end else if (nose) begin
            draw_color = NOSE_COLOR;
        end else begin
            draw_color = PLAYER_COLOR;
        end
    end

    always_comb begin
        state_d     = state_q;
        drawn_x_d   = drawn_x_q;
        drawn_y_d   = drawn_y_q;
        drawn_dir_d = drawn_dir_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        tgt_dir_d   = tgt_dir_q;
        px_d        = px_q;
        py_d        = py_q;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        vga_write_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            S_INIT_PEND: begin
                // Nothing is known to be on screen yet: draw without erasing.
                tgt_x_d   = x_position;
                tgt_y_d   = y_position;
                tgt_dir_d = dir;
                px_d      = '0;
                py_d      = '0;
                state_d   = S_DRAW;
            end
            S_IDLE: begin
                if ((x_position != drawn_x_q) || (y_position != drawn_y_q) ||
                    (dir != drawn_dir_q)) begin
                    tgt_x_d   = x_position;
                    tgt_y_d   = y_position;
                    tgt_dir_d = dir;
                    px_d      = '0;
                    py_d      = '0;
                    if ((x_position != drawn_x_q) || (y_position != drawn_y_q)) begin
                        state_d = S_ERASE;
                    end else begin
                        state_d = S_DRAW;
                    end
                end
            end
            S_ERASE, S_DRAW: begin
                vga_x_d     = 10'(X_OFF + 32'(tile_x) * TILE + px_v);
                vga_y_d     = 9'(Y_OFF + 32'(tile_y) * TILE + py_v);
                vga_color_d = (state_q == S_ERASE) ? FLOOR_COLOR : draw_color;
                // Off-grid tiles still take the full raster time, silently.
                vga_write_d = in_range;
                busy_d      = 1'b1;
                px_d        = last_px ? '0 : px_q + 1'b1;
                if (last_px) begin
                    py_d = last_py ? '0 : py_q + 1'b1;
                end
                if (last_px && last_py) begin
                    if (state_q == S_ERASE) begin
                        state_d = S_DRAW;
                    end else begin
                        drawn_x_d   = tgt_x_q;
                        drawn_y_d   = tgt_y_q;
                        drawn_dir_d = tgt_dir_q;
                        state_d     = S_DONE;
                    end
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_INIT_PEND;
            drawn_x_q   <= '0;
            drawn_y_q   <= '0;
            drawn_dir_q <= '0;
            tgt_x_q     <= '0;
            tgt_y_q     <= '0;
            tgt_dir_q   <= '0;
            px_q        <= '0;
            py_q        <= '0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            vga_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drawn_x_q   <= drawn_x_d;
            drawn_y_q   <= drawn_y_d;
            drawn_dir_q <= drawn_dir_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            tgt_dir_q   <= tgt_dir_d;
            px_q        <= px_d;
            py_q        <= py_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
            vga_write_q <= vga_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign vga_x     = vga_x_q;
    assign vga_y     = vga_y_q;
    assign vga_color = vga_color_q;
    assign vga_write = vga_write_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
